i2c_arbiter: RTL and testbench

- Shares the single `i2c` byte-level core among NUM_CLIENTS bus masters, for example the `adc` sampler plus a display or EEPROM driver.
- Each client drives the same instruction/enable/byte interface that `adc` already uses toward `i2c`.
- Arbitration is round-robin and works at transaction granularity: a client holds the bus from its START to its STOP.
- Sits between the client blocks and the `i2c` instance in the top level.

---
 rtl/i2c_arbiter_pkg.sv | 21 ++
 rtl/i2c_arbiter_if.sv | 33 +++
 rtl/i2c_arbiter_rr_pick.sv | 29 ++
 rtl/i2c_arbiter.sv | 107 ++++++++++
 tb/tb_i2c_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the i2c core, its clients and the bus arbiter:
// instruction encodings and arbiter state encodings.
package i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    I2C_START = 2'b00,
    I2C_STOP  = 2'b01,
    I2C_READ  = 2'b10,
    I2C_WRITE = 2'b11
  } i2cInstr_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_RELEASE = 2'd2
  } arbState_t;

  localparam int MIN_CLIENTS = 2;
  localparam int MAX_CLIENTS = 4;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Bundle of the client-side and core-side i2c byte interfaces around the arbiter.
// slave is the arbiter's view; master is the view of the clients plus the i2c core.
interface i2c_arbiter_if #(
  parameter int NUM_CLIENTS = 2
);
  logic [NUM_CLIENTS-1:0]   clientRequest;
  logic [NUM_CLIENTS-1:0]   clientGrant;
  logic [2*NUM_CLIENTS-1:0] clientInstruction;
  logic [NUM_CLIENTS-1:0]   clientEnable;
  logic [8*NUM_CLIENTS-1:0] clientByteToSend;
  logic [7:0]               clientByteReceived;
  logic [NUM_CLIENTS-1:0]   clientComplete;

  logic [1:0]               i2cInstruction;
  logic                     i2cEnable;
  logic [7:0]               i2cByteToSend;
  logic [7:0]               i2cByteReceived;
  logic                     i2cComplete;

  modport slave (
    input  clientRequest, clientInstruction, clientEnable, clientByteToSend,
           i2cByteReceived, i2cComplete,
    output clientGrant, clientByteReceived, clientComplete,
           i2cInstruction, i2cEnable, i2cByteToSend
  );

  modport master (
    output clientRequest, clientInstruction, clientEnable, clientByteToSend,
           i2cByteReceived, i2cComplete,
    input  clientGrant, clientByteReceived, clientComplete,
           i2cInstruction, i2cEnable, i2cByteToSend
  );
endinterface

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit after lastServed,
// wrapping modulo NUM_CLIENTS.
module rr_pick #(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_CLIENTS-1:0] request,
  input  logic [IDX_W-1:0]       lastServed,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  logic [IDX_W-1:0] candidate;

  // Scan from the farthest position back to the nearest so the nearest hit wins.
  always_comb begin
    winner    = '0;
    valid     = 1'b0;
    candidate = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      candidate = IDX_W'((int'(lastServed) + k) % NUM_CLIENTS);
      if (request[candidate]) begin
        winner = candidate;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin, transaction-granular arbiter sharing one i2c byte core among
// NUM_CLIENTS masters. A client owns the bus from its grant until it drops
// request, enable and the core's complete has closed.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ARB_IDLE    | no owner; grant the next requester on the coming edge
//   ARB_GRANTED | owner's instruction/enable/byte routed to the i2c core
//   ARB_RELEASE | one mandatory dead cycle, no grant, core enable forced 0
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = 1
) (
  input  logic             clk,
  input  logic             reset,
  i2c_arbiter_if.slave     bus,
  output logic             busBusy,
  output logic [IDX_W-1:0] owner
);

  arbState_t              state, stateNext;
  logic [NUM_CLIENTS-1:0] grantReg, grantNext;
  logic [IDX_W-1:0]       ownerNext;
  logic [IDX_W-1:0]       lastServed, lastServedNext;
  logic [IDX_W-1:0]       pickWinner;
  logic                   pickValid;
  logic                   ownerDone;

  rr_pick #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .request   (bus.clientRequest),
    .lastServed(lastServed),
    .winner    (pickWinner),
    .valid     (pickValid)
  );

  // Release only once the owner's handshake with the core has fully closed.
  assign ownerDone = !bus.clientRequest[owner] && !bus.clientEnable[owner] && !bus.i2cComplete;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grantReg   <= '0;
      owner      <= '0;
      lastServed <= IDX_W'(NUM_CLIENTS - 1);
    end else begin
      state      <= stateNext;
      grantReg   <= grantNext;
      owner      <= ownerNext;
      lastServed <= lastServedNext;
    end
  end

  always_comb begin
    stateNext      = state;
    grantNext      = grantReg;
    ownerNext      = owner;
    lastServedNext = lastServed;
    unique case (state)
      ARB_IDLE: begin
        grantNext = '0;
        if (pickValid) begin
          stateNext      = ARB_GRANTED;
          ownerNext      = pickWinner;
          lastServedNext = pickWinner;
          grantNext      = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pickWinner;
        end
      end
      ARB_GRANTED: begin
        if (ownerDone) begin
          stateNext = ARB_RELEASE;
          grantNext = '0;
        end
      end
      ARB_RELEASE: begin
        stateNext = ARB_IDLE;
        grantNext = '0;
      end
      default: begin
        stateNext = ARB_IDLE;
        grantNext = '0;
      end
    endcase
  end

  always_comb begin
    bus.i2cInstruction = '0;
    bus.i2cEnable      = 1'b0;
    bus.i2cByteToSend  = '0;
    bus.clientComplete = '0;
    if (state == ARB_GRANTED) begin
      bus.i2cInstruction         = bus.clientInstruction[owner*2 +: 2];
      bus.i2cEnable              = bus.clientEnable[owner];
      bus.i2cByteToSend          = bus.clientByteToSend[owner*8 +: 8];
      bus.clientComplete[owner]  = bus.i2cComplete;
    end
  end

  assign bus.clientGrant        = grantReg;
  assign bus.clientByteReceived = bus.i2cByteReceived;
  assign busBusy                = (state != ARB_IDLE);

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for the two-client i2c arbiter: reset, routing, hold-until-closed,
// round-robin ties, release gap, async reset mid-transaction and alternation.
module tb_i2c_arbiter;
  import i2c_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busBusy;
  logic [0:0] owner;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  i2c_arbiter_if #(.NUM_CLIENTS(2)) bus ();

  i2c_arbiter #(
    .NUM_CLIENTS(2),
    .IDX_W      (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busBusy(busBusy),
    .owner  (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    int cur;
    int nxt;
    reset                 = 1'b1;
    bus.clientRequest     = 2'b00;
    bus.clientEnable      = 2'b11;
    bus.clientInstruction = 4'b1111;
    bus.clientByteToSend  = 16'hAABB;
    bus.i2cByteReceived   = 8'h00;
    bus.i2cComplete       = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(bus.clientGrant), 32'h0);
    chk("rst_busy", 32'(busBusy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_en", 32'(bus.i2cEnable), 32'h0);
    chk("rst_instr", 32'(bus.i2cInstruction), 32'h0);
    chk("rst_byte", 32'(bus.i2cByteToSend), 32'h0);
    chk("rst_cmpl", 32'(bus.clientComplete), 32'h0);

    reset = 1'b0;
    tick();
    tick();
    tick();
    bus.clientInstruction = {I2C_READ, I2C_WRITE};
    bus.clientByteToSend  = {8'hAA, 8'h90};
    bus.clientEnable      = 2'b10;
    bus.i2cComplete       = 1'b0;
    bus.clientRequest     = 2'b01;
    #1;
    chk("pre_grant", 32'(bus.clientGrant), 32'h0);
    tick();
    chk("c0_grant", 32'(bus.clientGrant), 32'h1);
    chk("c0_owner", 32'(owner), 32'h0);
    chk("c0_busy", 32'(busBusy), 32'h1);
    chk("c0_instr", 32'(bus.i2cInstruction), 32'h3);
    chk("c0_byte", 32'(bus.i2cByteToSend), 32'h90);
    chk("c1_en_ignored", 32'(bus.i2cEnable), 32'h0);
    bus.clientEnable = 2'b11;
    #1;
    chk("c0_en", 32'(bus.i2cEnable), 32'h1);
    bus.i2cComplete     = 1'b1;
    bus.i2cByteReceived = 8'h5A;
    #1;
    chk("c0_cmpl", 32'(bus.clientComplete), 32'h1);
    chk("rx_bcast", 32'(bus.clientByteReceived), 32'h5A);

    bus.clientRequest = 2'b00;
    tick();
    chk("hold_en_cmpl", 32'(bus.clientGrant), 32'h1);
    bus.clientEnable = 2'b10;
    tick();
    chk("hold_cmpl", 32'(bus.clientGrant), 32'h1);
    bus.i2cComplete = 1'b0;
    tick();
    chk("rel_grant", 32'(bus.clientGrant), 32'h0);
    chk("rel_busy", 32'(busBusy), 32'h1);
    bus.clientEnable = 2'b11;
    #1;
    chk("rel_en_forced", 32'(bus.i2cEnable), 32'h0);
    chk("rel_cmpl", 32'(bus.clientComplete), 32'h0);
    bus.clientEnable = 2'b10;
    tick();
    chk("idle_busy", 32'(busBusy), 32'h0);
    chk("idle_grant", 32'(bus.clientGrant), 32'h0);
    chk("idle_owner_kept", 32'(owner), 32'h0);

    bus.clientRequest = 2'b11;
    tick();
    chk("tie_grant", 32'(bus.clientGrant), 32'h2);
    chk("tie_owner", 32'(owner), 32'h1);
    chk("c1_instr", 32'(bus.i2cInstruction), 32'h2);
    chk("c1_byte", 32'(bus.i2cByteToSend), 32'hAA);
    chk("c1_en", 32'(bus.i2cEnable), 32'h1);
    bus.clientEnable = 2'b01;
    #1;
    chk("c0_en_ignored", 32'(bus.i2cEnable), 32'h0);

    bus.clientRequest = 2'b01;
    bus.clientEnable  = 2'b00;
    tick();
    chk("gap_rel", 32'(bus.clientGrant), 32'h0);
    tick();
    chk("gap_idle", 32'(bus.clientGrant), 32'h0);
    tick();
    chk("gap_grant", 32'(bus.clientGrant), 32'h1);
    chk("gap_owner", 32'(owner), 32'h0);

    bus.clientEnable = 2'b01;
    #1;
    chk("pre_rst_en", 32'(bus.i2cEnable), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(bus.clientGrant), 32'h0);
    chk("async_en", 32'(bus.i2cEnable), 32'h0);
    chk("async_busy", 32'(busBusy), 32'h0);
    bus.clientEnable  = 2'b00;
    bus.clientRequest = 2'b11;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 32'(bus.clientGrant), 32'h1);
    chk("post_rst_owner", 32'(owner), 32'h0);

    for (int k = 0; k < 4; k++) begin
      cur = k % 2;
      nxt = 1 - cur;
      bus.clientRequest[cur] = 1'b0;
      tick();
      chk("alt_rel", 32'(bus.clientGrant), 32'h0);
      bus.clientRequest[cur] = 1'b1;
      tick();
      chk("alt_idle", 32'(bus.clientGrant), 32'h0);
      tick();
      chk("alt_grant", 32'(bus.clientGrant), 32'(1 << nxt));
      chk("alt_owner", 32'(owner), 32'(nxt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
